// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA scan generator: pixel-strobe divider, h/v counters, and registered
// position, display-enable, sync and line/frame marker outputs.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       h_sync,
  output logic       v_sync,
  output logic       pixel_stb,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] H_SS    = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SE    = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS    = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SE    = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  logic [9:0]       h_next, v_next;
  logic             tick, h_wrap;
  logic             de_next, hs_next, vs_next;

  always_comb begin
    tick    = (div_cnt == DIV_LAST);
    h_wrap  = (h_cnt == H_LAST);
    h_next  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_next  = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    de_next = (h_next < H_VIS) && (v_next < V_VIS);
    hs_next = ((h_next >= H_SS) && (h_next < H_SE)) ? SYNC_POL : ~SYNC_POL;
    vs_next = ((v_next >= V_SS) && (v_next < V_SE)) ? SYNC_POL : ~SYNC_POL;
  end

  // Counters preload to the last position so the first tick presents pixel (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      x           <= 10'd0;
      y           <= 10'd0;
      de          <= 1'b0;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      pixel_stb   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      pixel_stb   <= tick;
      line_start  <= tick && (h_next == 10'd0);
      frame_start <= tick && (h_next == 10'd0) && (v_next == 10'd0);
      if (tick) begin
        h_cnt  <= h_next;
        v_cnt  <= v_next;
        x      <= h_next;
        y      <= v_next;
        de     <= de_next;
        h_sync <= hs_next;
        v_sync <= vs_next;
      end
    end
  end

endmodule
